// File: rtl/parity_frame_ctrl_pkg.sv
// Shared types and constants for the parity frame controller.
package parity_frame_pkg;

    localparam int WORD_W = 3;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_RUN,
        PF_DONE
    } pf_state_t;

    // Counter width that holds 0..frame_len inclusive.
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/parity_frame_ctrl_if.sv
// Word-input and frame-result handshake bundle of the parity frame controller.
interface parity_frame_ctrl_if #(
    parameter int CNT_W = 4
);
    logic                                in_valid;
    logic                                in_ready;
    logic [parity_frame_pkg::WORD_W-1:0] in_data;
    logic                                out_valid;
    logic                                out_ready;
    logic                                frame_odd;
    logic                                frame_even;
    logic [CNT_W-1:0]                    odd_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, frame_odd, frame_even, odd_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, frame_odd, frame_even, odd_cnt
    );
endinterface

// File: rtl/parity_frame_ctrl_parity3_word.sv
// Combinational even/odd parity of one 3-bit word.
module parity3_word
    import parity_frame_pkg::*;
(
    input  logic [WORD_W-1:0] w,
    output logic              odd,
    output logic              even
);
    assign odd  = ^w;
    assign even = ~^w;
endmodule

// File: rtl/parity_frame_ctrl.sv
// Frame sequencer: accumulates word parity over FRAME_LEN words and presents one result.
// Optional odd-word statistics are enabled by defining PFC_STATS_EN.
module parity_frame_ctrl
    import parity_frame_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    parity_frame_ctrl_if.slave bus
);
    localparam int               CNT_W    = cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    pf_state_t        state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             acc_par_q, acc_par_d;
    logic [CNT_W-1:0] odd_total;
    logic             word_odd, word_even, wpar;
    logic             accept, clear, done;

    parity3_word u_parity (
        .w    (bus.in_data),
        .odd  (word_odd),
        .even (word_even)
    );

    // Both rails of the parity cell must agree before a word counts as odd.
    assign wpar   = word_odd & ~word_even;
    assign accept = (state_q == PF_RUN) & bus.in_valid;
    assign clear  = abort | (state_q == PF_IDLE);
    assign done   = (state_q == PF_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PF_IDLE;
            wcnt_q    <= '0;
            acc_par_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            acc_par_q <= acc_par_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PF_IDLE: if (start && !abort) state_d = PF_RUN;
            PF_RUN: begin
                if (abort)                            state_d = PF_IDLE;
                else if (accept && wcnt_q == LAST_IDX) state_d = PF_DONE;
            end
            PF_DONE: if (abort || bus.out_ready) state_d = PF_IDLE;
            default: state_d = PF_IDLE;
        endcase
    end

    // The word counter parks on the last index so it never exceeds FRAME_LEN-1.
    always_comb begin
        wcnt_d    = wcnt_q;
        acc_par_d = acc_par_q;
        if (clear) begin
            wcnt_d    = '0;
            acc_par_d = 1'b0;
        end else if (accept) begin
            acc_par_d = acc_par_q ^ wpar;
            if (wcnt_q != LAST_IDX) wcnt_d = wcnt_q + CNT_W'(1);
        end
    end

`ifdef PFC_STATS_EN
    logic [CNT_W-1:0] acc_odd_q, acc_odd_d;

    always_ff @(posedge clk) begin
        if (rst) acc_odd_q <= '0;
        else     acc_odd_q <= acc_odd_d;
    end

    always_comb begin
        acc_odd_d = acc_odd_q;
        if (clear)       acc_odd_d = '0;
        else if (accept) acc_odd_d = acc_odd_q + CNT_W'(wpar);
    end

    assign odd_total = acc_odd_q;
`else
    assign odd_total = '0;
`endif

    always_comb begin
        bus.in_ready   = (state_q == PF_RUN);
        bus.out_valid  = done;
        bus.frame_odd  = done & acc_par_q;
        bus.frame_even = done & ~acc_par_q;
        bus.odd_cnt    = done ? odd_total : '0;
        busy           = (state_q != PF_IDLE);
    end
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed self-checking bench for parity_frame_ctrl (FRAME_LEN=8 plus a FRAME_LEN=1 instance).
module tb_parity_frame_ctrl;
    import parity_frame_pkg::*;

    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = cnt_width(FRAME_LEN);
`ifdef PFC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, abort, busy;
    logic start1, busy1;
    int   errors = 0;
    int   checks = 0;

    parity_frame_ctrl_if #(.CNT_W(CNT_W)) bus ();
    parity_frame_ctrl_if #(.CNT_W(1))     bus1 ();

    parity_frame_ctrl #(.FRAME_LEN(FRAME_LEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .bus   (bus.slave)
    );

    parity_frame_ctrl #(.FRAME_LEN(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .abort (abort),
        .busy  (busy1),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    function automatic int oc(input int n);
        return STATS ? n : 0;
    endfunction

    task automatic checkVal(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        assert (actual === expected) else begin
            errors++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, then step past the next rising edge.
    task automatic applyStimulus(input logic s, input logic ab, input logic v,
                                 input logic [2:0] d, input logic ordy);
        start         = s;
        abort         = ab;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic ir, input logic ov, input logic fo,
                               input logic fe, input int cnt, input logic b);
        checkVal({tag, ".in_ready"},   8'(bus.in_ready),   8'(ir));
        checkVal({tag, ".out_valid"},  8'(bus.out_valid),  8'(ov));
        checkVal({tag, ".frame_odd"},  8'(bus.frame_odd),  8'(fo));
        checkVal({tag, ".frame_even"}, 8'(bus.frame_even), 8'(fe));
        checkVal({tag, ".odd_cnt"},    8'(bus.odd_cnt),    8'(cnt));
        checkVal({tag, ".busy"},       8'(busy),           8'(b));
    endtask

    initial begin
        rst            = 1'b1;
        start1         = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = 3'b000;
        bus1.out_ready = 1'b0;
        applyStimulus(0, 0, 0, 3'b000, 0);
        applyStimulus(0, 0, 0, 3'b000, 0);
        checkOutput("reset", 0, 0, 0, 0, 0, 0);
        checkVal("reset.fl1_busy", 8'(busy1), 8'd0);
        rst = 1'b0;

        $display("[TB] test 1: back-to-back 000..111");
        applyStimulus(1, 0, 0, 3'b000, 0);
        checkOutput("t1_start", 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 3'(i), 0);
            if (i < 7) checkOutput("t1_run", 1, 0, 0, 0, 0, 1);
        end
        checkOutput("t1_done", 0, 1, 0, 1, oc(4), 1);
        applyStimulus(0, 0, 0, 3'b000, 1);
        checkOutput("t1_idle", 0, 0, 0, 0, 0, 0);

        $display("[TB] test 2: 8x 001 with gaps, held result");
        applyStimulus(1, 0, 0, 3'b000, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 3'b000, 0);
            checkOutput("t2_gap", 1, 0, 0, 0, 0, 1);
            applyStimulus(0, 0, 1, 3'b001, 0);
            if (i < 7) checkOutput("t2_run", 1, 0, 0, 0, 0, 1);
        end
        checkOutput("t2_done", 0, 1, 0, 1, oc(8), 1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 3'b000, 0);
            checkOutput("t2_hold", 0, 1, 0, 1, oc(8), 1);
        end
        applyStimulus(0, 0, 0, 3'b000, 1);
        checkOutput("t2_idle", 0, 0, 0, 0, 0, 0);

        $display("[TB] test 3: 7x 000 then 111, start in DONE");
        applyStimulus(1, 0, 0, 3'b000, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 1, 3'b000, 0);
            checkOutput("t3_run", 1, 0, 0, 0, 0, 1);
        end
        applyStimulus(0, 0, 1, 3'b111, 0);
        checkOutput("t3_done", 0, 1, 1, 0, oc(1), 1);
        applyStimulus(1, 0, 0, 3'b000, 0);
        checkOutput("t3_start_ignored", 0, 1, 1, 0, oc(1), 1);
        applyStimulus(0, 0, 0, 3'b000, 1);
        checkOutput("t3_idle", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 3'b000, 0);
        checkOutput("t3_idle2", 0, 0, 0, 0, 0, 0);

        $display("[TB] test 4: abort mid-frame, then 8x 011");
        applyStimulus(1, 1, 0, 3'b000, 0);
        checkOutput("t4_abort_beats_start", 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 3'b000, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 3'b101, 0);
        checkOutput("t4_pre_abort", 1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 3'b101, 0);
        checkOutput("t4_abort", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 0, 0, 3'b000, 0);
            checkOutput("t4_after", 0, 0, 0, 0, 0, 0);
        end
        applyStimulus(1, 0, 0, 3'b000, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 3'b011, 0);
        checkOutput("t4_done", 0, 1, 0, 1, oc(0), 1);
        applyStimulus(0, 0, 0, 3'b000, 1);
        checkOutput("t4_idle", 0, 0, 0, 0, 0, 0);

        $display("[TB] test 5: reset mid-RUN and in DONE");
        applyStimulus(1, 0, 0, 3'b000, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 3'b111, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 1, 3'b111, 0);
        checkOutput("t5_rst_run", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(1, 0, 0, 3'b000, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 3'b111, 0);
            if (i < 7) checkOutput("t5_run", 1, 0, 0, 0, 0, 1);
        end
        checkOutput("t5_done", 0, 1, 0, 1, oc(8), 1);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 3'b000, 0);
        checkOutput("t5_rst_done", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        $display("[TB] test 6: FRAME_LEN=1 instance");
        start1 = 1'b1;
        tick();
        checkVal("fl1_run.in_ready", 8'(bus1.in_ready), 8'd1);
        checkVal("fl1_run.busy", 8'(busy1), 8'd1);
        start1        = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 3'b100;
        tick();
        bus1.in_valid = 1'b0;
        checkVal("fl1_done.out_valid", 8'(bus1.out_valid), 8'd1);
        checkVal("fl1_done.frame_odd", 8'(bus1.frame_odd), 8'd1);
        checkVal("fl1_done.frame_even", 8'(bus1.frame_even), 8'd0);
        checkVal("fl1_done.odd_cnt", 8'(bus1.odd_cnt), 8'(oc(1)));
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        checkVal("fl1_idle.out_valid", 8'(bus1.out_valid), 8'd0);
        checkVal("fl1_idle.busy", 8'(busy1), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
